// File: rtl/xintf_dpbram_slave_if.sv
// XINTF bus bundle between the TMS320 external interface and the
// FPGA-side dual-port RAM bridge. Signal names carry the direction as
// seen from the FPGA (slave) side.
interface xintf_dpbram_slave_if;
  logic        i_xintf_zcs_n;
  logic        i_xintf_rd_n;
  logic        i_xintf_we_n;
  logic [8:0]  i_xintf_addr;
  logic [15:0] i_xintf_data;
  logic [15:0] o_xintf_data;
  logic        o_xintf_data_oe;

  // DSP side drives strobes, address and write data
  modport master (
    output i_xintf_zcs_n,
    output i_xintf_rd_n,
    output i_xintf_we_n,
    output i_xintf_addr,
    output i_xintf_data,
    input  o_xintf_data,
    input  o_xintf_data_oe
  );

  // FPGA bridge samples the bus and returns read data
  modport slave (
    input  i_xintf_zcs_n,
    input  i_xintf_rd_n,
    input  i_xintf_we_n,
    input  i_xintf_addr,
    input  i_xintf_data,
    output o_xintf_data,
    output o_xintf_data_oe
  );
endinterface

// File: rtl/xintf_dpbram_slave.sv
// DSP-side bridge of the shared XINTF dual-port RAM. Asynchronous XINTF
// read/write strobes are synchronized, edge-detected and turned into
// single-cycle port-B RAM accesses. Writes to 0x1FE ring the block
// transfer doorbell; reads of 0x1FF return a status word.
module xintf_dpbram_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int DSP_BASE    = 128
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  xintf_dpbram_slave_if.slave        xintf,
  output logic [8:0]                 o_ram_addr,
  output logic [15:0]                o_ram_din,
  output logic                       o_ram_we,
  output logic                       o_ram_ce,
  input  logic [15:0]                i_ram_dout,
  input  logic                       i_w_valid,
  output logic                       o_w_ready,
  output logic                       o_r_valid,
  output logic [7:0]                 o_err_cnt,
  output logic [2:0]                 o_state
);

  localparam int              FILL_W     = $clog2(SYNC_STAGES + 1);
  localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(SYNC_STAGES);
  localparam logic [8:0]      DSP_BASE_A = 9'(DSP_BASE);
  localparam logic [8:0]      ADDR_DB    = 9'h1FE;
  localparam logic [8:0]      ADDR_STAT  = 9'h1FF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_ADDR   = 3'd1,
    ST_RD_DATA   = 3'd2,
    ST_RD_HOLD   = 3'd3,
    ST_WR_COMMIT = 3'd4,
    ST_DOORBELL  = 3'd5
  } state_t;

  // True for addresses the DSP is allowed to commit into RAM
  function automatic logic is_dsp_addr(input logic [8:0] a);
    return (a >= DSP_BASE_A) && (a <= 9'h1FD);
  endfunction

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] rd_sync_q, rd_sync_d;
  logic [SYNC_STAGES-1:0] we_sync_q, we_sync_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic                   rdcs_prev_q, rdcs_prev_d;
  logic                   we_prev_q, we_prev_d;
  logic                   we_arm_q, we_arm_d;
  logic [8:0]             addr_q, addr_d;
  logic [15:0]            data_q, data_d;
  logic [15:0]            xdata_q, xdata_d;
  logic                   oe_q, oe_d;
  logic [8:0]             ram_addr_q, ram_addr_d;
  logic [15:0]            ram_din_q, ram_din_d;
  logic                   ram_we_q, ram_we_d;
  logic                   ram_ce_q, ram_ce_d;
  logic                   ack_pend_q, ack_pend_d;
  logic                   w_ready_q, w_ready_d;
  logic                   r_valid_q, r_valid_d;
  logic [7:0]             err_cnt_q, err_cnt_d;

  logic        cs, rd, we, rdcs, sync_ready;
  logic        rd_start, we_end;
  logic        err_inc, db_ack_set, w_fire;
  logic [15:0] status_word;

  // Synchronizers, edge detection, FSM and registered output next-state
  always_comb begin
    cs_sync_d = {cs_sync_q[SYNC_STAGES-2:0], xintf.i_xintf_zcs_n};
    rd_sync_d = {rd_sync_q[SYNC_STAGES-2:0], xintf.i_xintf_rd_n};
    we_sync_d = {we_sync_q[SYNC_STAGES-2:0], xintf.i_xintf_we_n};

    cs   = ~cs_sync_q[SYNC_STAGES-1];
    rd   = ~rd_sync_q[SYNC_STAGES-1];
    we   = ~we_sync_q[SYNC_STAGES-1];
    rdcs = cs & rd;

    // Until the synchronizers hold real samples after reset, the history
    // flops are pinned so a strobe held through reset cannot look like an edge.
    sync_ready = (fill_q == FILL_DONE);
    if (sync_ready) begin
      fill_d      = fill_q;
      rdcs_prev_d = rdcs;
      we_prev_d   = we;
    end else begin
      fill_d      = fill_q + FILL_W'(1);
      rdcs_prev_d = 1'b1;
      we_prev_d   = 1'b0;
    end
    // A write cycle only counts once its strobe has been seen inactive
    we_arm_d = we_arm_q | (sync_ready & ~we);

    rd_start = rdcs & ~rdcs_prev_q;
    we_end   = cs & ~we & we_prev_q & we_arm_q;

    status_word = {13'b0, ack_pend_q, i_w_valid, 1'b1};

    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    xdata_d    = xdata_q;
    err_inc    = 1'b0;
    db_ack_set = 1'b0;
    r_valid_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rd_start) begin
          state_d = ST_RD_ADDR;
          addr_d  = xintf.i_xintf_addr;
          // A write ending in the same cycle loses to the read
          err_inc = we_end;
        end else if (we_end) begin
          state_d = ST_WR_COMMIT;
          addr_d  = xintf.i_xintf_addr;
          data_d  = xintf.i_xintf_data;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (addr_q == ADDR_STAT) begin
          xdata_d = status_word;
        end else begin
          xdata_d = i_ram_dout;
        end
        state_d = ST_RD_HOLD;
      end
      ST_RD_HOLD: begin
        if (!rdcs) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RD_HOLD;
        end
      end
      ST_WR_COMMIT: begin
        if (addr_q == ADDR_DB) begin
          state_d = ST_DOORBELL;
        end else begin
          err_inc = ~is_dsp_addr(addr_q);
          state_d = ST_IDLE;
        end
      end
      ST_DOORBELL: begin
        r_valid_d  = data_q[0];
        db_ack_set = data_q[1];
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // RAM port outputs are registered copies for the state being entered
    if (state_d == ST_RD_ADDR) begin
      ram_ce_d   = 1'b1;
      ram_we_d   = 1'b0;
      ram_addr_d = addr_d;
      ram_din_d  = 16'h0000;
    end else if ((state_d == ST_WR_COMMIT) && is_dsp_addr(addr_d)) begin
      ram_ce_d   = 1'b1;
      ram_we_d   = 1'b1;
      ram_addr_d = addr_d;
      ram_din_d  = data_d;
    end else begin
      ram_ce_d   = 1'b0;
      ram_we_d   = 1'b0;
      ram_addr_d = 9'h000;
      ram_din_d  = 16'h0000;
    end

    oe_d = (state_d == ST_RD_HOLD);

    // Doorbell acknowledge: one pulse per pending request, extra requests absorbed
    w_fire     = ack_pend_q & i_w_valid;
    w_ready_d  = w_fire;
    ack_pend_d = (ack_pend_q & ~w_fire) | db_ack_set;

    if (err_inc && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cs_sync_q   <= {SYNC_STAGES{1'b1}};
      rd_sync_q   <= {SYNC_STAGES{1'b1}};
      we_sync_q   <= {SYNC_STAGES{1'b1}};
      fill_q      <= {FILL_W{1'b0}};
      rdcs_prev_q <= 1'b1;
      we_prev_q   <= 1'b0;
      we_arm_q    <= 1'b0;
      addr_q      <= 9'h000;
      data_q      <= 16'h0000;
      xdata_q     <= 16'h0000;
      oe_q        <= 1'b0;
      ram_addr_q  <= 9'h000;
      ram_din_q   <= 16'h0000;
      ram_we_q    <= 1'b0;
      ram_ce_q    <= 1'b0;
      ack_pend_q  <= 1'b0;
      w_ready_q   <= 1'b0;
      r_valid_q   <= 1'b0;
      err_cnt_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      cs_sync_q   <= cs_sync_d;
      rd_sync_q   <= rd_sync_d;
      we_sync_q   <= we_sync_d;
      fill_q      <= fill_d;
      rdcs_prev_q <= rdcs_prev_d;
      we_prev_q   <= we_prev_d;
      we_arm_q    <= we_arm_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      xdata_q     <= xdata_d;
      oe_q        <= oe_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      ram_we_q    <= ram_we_d;
      ram_ce_q    <= ram_ce_d;
      ack_pend_q  <= ack_pend_d;
      w_ready_q   <= w_ready_d;
      r_valid_q   <= r_valid_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign xintf.o_xintf_data    = xdata_q;
  assign xintf.o_xintf_data_oe = oe_q;
  assign o_ram_addr = ram_addr_q;
  assign o_ram_din  = ram_din_q;
  assign o_ram_we   = ram_we_q;
  assign o_ram_ce   = ram_ce_q;
  assign o_w_ready  = w_ready_q;
  assign o_r_valid  = r_valid_q;
  assign o_err_cnt  = err_cnt_q;
  assign o_state    = state_q;

endmodule

// File: tb/tb_xintf_dpbram_slave.sv
// Directed bench for xintf_dpbram_slave: reads, legal/illegal writes,
// error saturation, doorbell handshake, read/write collision and reset
// in the middle of a read.
module tb_xintf_dpbram_slave;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ram_dout;
  logic        w_valid = 1'b0;
  logic [8:0]  ram_addr;
  logic [15:0] ram_din;
  logic        ram_we, ram_ce, w_ready, r_valid;
  logic [7:0]  err_cnt;
  logic [2:0]  state;

  logic        pre_we = 1'b0;
  logic [8:0]  pre_addr = 9'h000;
  logic [15:0] pre_data = 16'h0000;
  logic [15:0] mem [512];

  int n_checks = 0;
  int n_errors = 0;
  int we_cnt = 0, ce_cnt = 0, rv_cnt = 0, wr_cnt = 0;
  logic [8:0]  last_we_addr = 9'h000;
  logic [15:0] last_we_din  = 16'h0000;

  xintf_dpbram_slave_if bus ();

  xintf_dpbram_slave #(.SYNC_STAGES(2), .DSP_BASE(128)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .xintf      (bus),
    .o_ram_addr (ram_addr),
    .o_ram_din  (ram_din),
    .o_ram_we   (ram_we),
    .o_ram_ce   (ram_ce),
    .i_ram_dout (ram_dout),
    .i_w_valid  (w_valid),
    .o_w_ready  (w_ready),
    .o_r_valid  (r_valid),
    .o_err_cnt  (err_cnt),
    .o_state    (state)
  );

  always #5 clk = ~clk;

  // Port-B RAM model with a bench preload port; read data one cycle after ce
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_ce && ram_we) mem[ram_addr] <= ram_din;
    if (ram_ce) ram_dout <= mem[ram_addr];
  end

  // Pulse counters on DUT outputs
  always @(posedge clk) begin
    if (ram_we) begin
      we_cnt       <= we_cnt + 1;
      last_we_addr <= ram_addr;
      last_we_din  <= ram_din;
    end
    if (ram_ce)  ce_cnt <= ce_cnt + 1;
    if (r_valid) rv_cnt <= rv_cnt + 1;
    if (w_ready) wr_cnt <= wr_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic preload(input logic [8:0] a, input logic [15:0] d);
    @(negedge clk); pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk); pre_we = 1'b0;
  endtask

  // Read with cycle-accurate checks relative to the raw rd_n fall
  task automatic do_read(input logic [8:0] a, input logic [15:0] exp_d, input string tag);
    int ce0;
    ce0 = ce_cnt;
    @(negedge clk);
    bus.i_xintf_zcs_n = 1'b0; bus.i_xintf_rd_n = 1'b0; bus.i_xintf_addr = a;
    repeat (3) @(negedge clk);
    check_val({tag, "_ce_c3"}, {31'b0, ram_ce}, 32'd1);
    check_val({tag, "_addr_c3"}, {23'b0, ram_addr}, {23'b0, a});
    @(negedge clk);
    check_val({tag, "_oe_c4"}, {31'b0, bus.o_xintf_data_oe}, 32'd0);
    @(negedge clk);
    check_val({tag, "_oe_c5"}, {31'b0, bus.o_xintf_data_oe}, 32'd1);
    check_val({tag, "_data_c5"}, {16'b0, bus.o_xintf_data}, {16'b0, exp_d});
    @(negedge clk);
    bus.i_xintf_zcs_n = 1'b1; bus.i_xintf_rd_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val({tag, "_oe_r2"}, {31'b0, bus.o_xintf_data_oe}, 32'd1);
    @(negedge clk);
    check_val({tag, "_oe_r3"}, {31'b0, bus.o_xintf_data_oe}, 32'd0);
    check_val({tag, "_ce_count"}, 32'(ce_cnt - ce0), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // Write with RAM write pulse checked 3..4 cycles after the raw we_n rise
  task automatic do_write(input logic [8:0] a, input logic [15:0] d, input logic exp_we, input string tag);
    int we0;
    we0 = we_cnt;
    @(negedge clk);
    bus.i_xintf_zcs_n = 1'b0; bus.i_xintf_we_n = 1'b0;
    bus.i_xintf_addr = a; bus.i_xintf_data = d;
    repeat (3) @(negedge clk);
    bus.i_xintf_we_n = 1'b1;
    repeat (2) @(negedge clk);
    check_val({tag, "_we_early"}, {31'b0, ram_we}, 32'd0);
    @(negedge clk);
    check_val({tag, "_we_pos"}, {31'b0, ram_we}, {31'b0, exp_we});
    bus.i_xintf_zcs_n = 1'b1;
    repeat (4) @(negedge clk);
    check_val({tag, "_we_count"}, 32'(we_cnt - we0), {31'b0, exp_we});
    if (exp_we) begin
      check_val({tag, "_we_addr"}, {23'b0, last_we_addr}, {23'b0, a});
      check_val({tag, "_we_din"}, {16'b0, last_we_din}, {16'b0, d});
    end
  endtask

  initial begin
    int rv0, wr0, we0, ce0;
    bus.i_xintf_zcs_n = 1'b1; bus.i_xintf_rd_n = 1'b1; bus.i_xintf_we_n = 1'b1;
    bus.i_xintf_addr = 9'h000; bus.i_xintf_data = 16'h0000;

    // Reset values
    repeat (3) @(negedge clk);
    check_val("rst_oe", {31'b0, bus.o_xintf_data_oe}, 32'd0);
    check_val("rst_xdata", {16'b0, bus.o_xintf_data}, 32'd0);
    check_val("rst_ram", {5'b0, ram_ce, ram_we, ram_addr, ram_din}, 32'd0);
    check_val("rst_hs", {30'b0, w_ready, r_valid}, 32'd0);
    check_val("rst_err", {24'b0, err_cnt}, 32'd0);
    check_val("rst_state", {29'b0, state}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    preload(9'd10, 16'hA5A5);
    preload(9'd140, 16'hBEEF);

    // Basic read
    do_read(9'd10, 16'hA5A5, "rd10");

    // Legal write then read back through RAM
    do_write(9'd130, 16'h1234, 1'b1, "wr130");
    check_val("wr130_err", {24'b0, err_cnt}, 32'd0);
    do_read(9'd130, 16'h1234, "rd130");

    // Illegal writes
    do_write(9'd20, 16'h5555, 1'b0, "wr20");
    do_write(9'h1FF, 16'h6666, 1'b0, "wr1ff");
    check_val("illegal_err2", {24'b0, err_cnt}, 32'd2);

    // Read/write collision: we_n rises as rd_n falls
    we0 = we_cnt;
    @(negedge clk);
    bus.i_xintf_zcs_n = 1'b0; bus.i_xintf_we_n = 1'b0;
    bus.i_xintf_addr = 9'd140; bus.i_xintf_data = 16'h7777;
    repeat (4) @(negedge clk);
    bus.i_xintf_rd_n = 1'b0; bus.i_xintf_we_n = 1'b1;
    repeat (5) @(negedge clk);
    check_val("coll_oe", {31'b0, bus.o_xintf_data_oe}, 32'd1);
    check_val("coll_data", {16'b0, bus.o_xintf_data}, 32'h0000BEEF);
    bus.i_xintf_zcs_n = 1'b1; bus.i_xintf_rd_n = 1'b1;
    repeat (6) @(negedge clk);
    check_val("coll_we_count", 32'(we_cnt - we0), 32'd0);
    check_val("coll_err", {24'b0, err_cnt}, 32'd3);

    // Saturation: 300 illegal writes in total
    for (int i = 0; i < 297; i++) do_write(9'd5, 16'(i), 1'b0, "sat");
    check_val("sat_err255", {24'b0, err_cnt}, 32'd255);
    do_write(9'd6, 16'h0001, 1'b0, "sat_more");
    check_val("sat_hold255", {24'b0, err_cnt}, 32'd255);

    // Doorbell 0x0003 with w_valid low
    rv0 = rv_cnt; wr0 = wr_cnt;
    do_write(9'h1FE, 16'h0003, 1'b0, "db3");
    check_val("db3_rvalid", 32'(rv_cnt - rv0), 32'd1);
    check_val("db3_wready", 32'(wr_cnt - wr0), 32'd0);
    check_val("db3_err", {24'b0, err_cnt}, 32'd255);
    do_read(9'h1FF, 16'h0005, "stat_pend");
    w_valid = 1'b1;
    repeat (5) @(negedge clk);
    check_val("db3_wready_pulse", 32'(wr_cnt - wr0), 32'd1);
    do_read(9'h1FF, 16'h0003, "stat_valid");
    w_valid = 1'b0;
    repeat (2) @(negedge clk);
    do_read(9'h1FF, 16'h0001, "stat_idle");

    // Two bit1-only doorbells while pending give a single acknowledge
    rv0 = rv_cnt; wr0 = wr_cnt;
    do_write(9'h1FE, 16'h0002, 1'b0, "db2a");
    do_write(9'h1FE, 16'h0002, 1'b0, "db2b");
    check_val("db2_rvalid", 32'(rv_cnt - rv0), 32'd0);
    w_valid = 1'b1;
    repeat (6) @(negedge clk);
    check_val("db2_wready_once", 32'(wr_cnt - wr0), 32'd1);
    w_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while in RD_HOLD with rd_n held low
    @(negedge clk);
    bus.i_xintf_zcs_n = 1'b0; bus.i_xintf_rd_n = 1'b0; bus.i_xintf_addr = 9'd10;
    repeat (6) @(negedge clk);
    check_val("mid_oe_before", {31'b0, bus.o_xintf_data_oe}, 32'd1);
    rst = 1'b1;
    #1;
    check_val("mid_oe", {31'b0, bus.o_xintf_data_oe}, 32'd0);
    check_val("mid_xdata", {16'b0, bus.o_xintf_data}, 32'd0);
    check_val("mid_state", {29'b0, state}, 32'd0);
    check_val("mid_err", {24'b0, err_cnt}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ce0 = ce_cnt;
    repeat (10) @(negedge clk);
    check_val("post_rst_no_ce", 32'(ce_cnt - ce0), 32'd0);
    check_val("post_rst_oe", {31'b0, bus.o_xintf_data_oe}, 32'd0);
    check_val("post_rst_state", {29'b0, state}, 32'd0);
    bus.i_xintf_zcs_n = 1'b1; bus.i_xintf_rd_n = 1'b1;
    repeat (4) @(negedge clk);
    do_read(9'd10, 16'hA5A5, "rd_fresh");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
